// File: rtl/mold_pkg.sv
// Shared constants and FSM state type for the MoldUDP64 retransmission request generator.
package mold_pkg;

  localparam int unsigned SEQ_NUM_W_DEF = 64;
  localparam int unsigned SID_W_DEF     = 80;
  localparam int unsigned ML_W_DEF      = 16;
  localparam int unsigned REQ_BYTES     = 20;

  // Largest message count a single request can carry for a given count width.
  function automatic longint unsigned chunk_max(input int unsigned ml_w);
    return (64'd1 << ml_w) - 64'd1;
  endfunction

  localparam longint unsigned CHUNK_MAX = chunk_max(ML_W_DEF);

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

endpackage

// File: rtl/miss_fifo.sv
// Synchronous FIFO of pending miss reports; also exposes the entry that follows the head.
module miss_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             next_valid_o,
  output logic [WIDTH-1:0] next_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [AW:0]      count_q, count_d;

  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Entry that becomes head once the current head is popped (bypasses a same-cycle push).
  assign next_valid_o = (count_q >= (AW+1)'(2)) || ((count_q == (AW+1)'(1)) && push_i);
  assign next_data_o  = (count_q >= (AW+1)'(2)) ? mem_q[rd_nxt] : wdata_i;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mold_retrans_req.sv
// Turns miss reports into 20-byte MoldUDP64 request packets, split into count-limited chunks.
module mold_retrans_req
  import mold_pkg::*;
#(
  parameter int unsigned SEQ_NUM_W  = SEQ_NUM_W_DEF,
  parameter int unsigned SID_W      = SID_W_DEF,
  parameter int unsigned ML_W       = ML_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [63:0]          req_data_o,
  output logic [7:0]           req_keep_o,
  output logic                 req_last_o,
  output logic [7:0]           drop_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned EntW = SID_W + 2 * SEQ_NUM_W;
  localparam int unsigned PktW = 8 * REQ_BYTES;
  localparam logic [SEQ_NUM_W-1:0] ChunkMax = SEQ_NUM_W'(chunk_max(ML_W));

  state_e               state_q, state_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  logic [SEQ_NUM_W-1:0] seq_q, seq_d, rem_q, rem_d;
  logic [7:0]           drop_q, drop_d;

  logic                 rpt_v, fifo_push, fifo_pop, fifo_full, fifo_empty, next_valid;
  logic [EntW-1:0]      wdata, rdata, next_data, load_ent;
  logic                 load;
  logic [SEQ_NUM_W-1:0] chunk, rem_after;
  logic [PktW-1:0]      pkt;

  assign rpt_v     = miss_v_i && (miss_cnt_i != '0);
  assign wdata     = {miss_sid_i, miss_seq_start_i, miss_cnt_i};
  assign chunk     = (rem_q > ChunkMax) ? ChunkMax : rem_q;
  assign rem_after = rem_q - chunk;
  assign fifo_pop  = (state_q == StB2) && req_ready_i && (rem_after == '0);
  assign fifo_push = rpt_v && (!fifo_full || fifo_pop);

  miss_fifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .nreset       (nreset),
    .push_i       (fifo_push),
    .wdata_i      (wdata),
    .pop_i        (fifo_pop),
    .rdata_o      (rdata),
    .next_valid_o (next_valid),
    .next_data_o  (next_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    sid_d    = sid_q;
    seq_d    = seq_q;
    rem_d    = rem_q;
    load     = 1'b0;
    load_ent = rdata;
    unique case (state_q)
      StIdle: begin
        // An empty FIFO with a push lets the report start without waiting a cycle.
        if (!fifo_empty) begin
          load = 1'b1;
        end else if (fifo_push) begin
          load     = 1'b1;
          load_ent = wdata;
        end
      end
      StB0: if (req_ready_i) state_d = StB1;
      StB1: if (req_ready_i) state_d = StB2;
      StB2: begin
        if (req_ready_i) begin
          seq_d = seq_q + chunk;
          rem_d = rem_after;
          if (rem_after != '0) begin
            state_d = StB0;
          end else if (next_valid) begin
            load     = 1'b1;
            load_ent = next_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      sid_d   = load_ent[EntW-1 -: SID_W];
      seq_d   = load_ent[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
      rem_d   = load_ent[SEQ_NUM_W-1:0];
      state_d = StB0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (rpt_v && fifo_full && !fifo_pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Packet byte 0 sits in the top byte of pkt; each beat puts byte k in lane k%8.
  assign pkt = {80'(sid_q), 64'(seq_q), 16'(chunk)};

  always_comb begin
    req_valid_o = 1'b0;
    req_data_o  = '0;
    req_keep_o  = '0;
    req_last_o  = 1'b0;
    unique case (state_q)
      StB0: begin
        req_valid_o = 1'b1;
        req_keep_o  = 8'hFF;
        for (int k = 0; k < 8; k++) req_data_o[8*k +: 8] = pkt[PktW-1-8*k -: 8];
      end
      StB1: begin
        req_valid_o = 1'b1;
        req_keep_o  = 8'hFF;
        for (int k = 0; k < 8; k++) req_data_o[8*k +: 8] = pkt[PktW-65-8*k -: 8];
      end
      StB2: begin
        req_valid_o = 1'b1;
        req_keep_o  = 8'h0F;
        req_last_o  = 1'b1;
        for (int k = 0; k < 4; k++) req_data_o[8*k +: 8] = pkt[PktW-129-8*k -: 8];
      end
      default: ;
    endcase
  end

  assign drop_cnt_o = drop_q;
  assign busy_o     = !fifo_empty || (state_q != StIdle);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      sid_q   <= '0;
      seq_q   <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sid_q   <= sid_d;
      seq_q   <= seq_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_mold_retrans_req.sv
// Directed bench for mold_retrans_req: packet format, chunking, drops, stalls and reset.
module tb_mold_retrans_req;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        miss_v_i = 1'b0;
  logic [79:0] miss_sid_i = '0;
  logic [63:0] miss_seq_start_i = '0;
  logic [63:0] miss_cnt_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [63:0] req_data_o;
  logic [7:0]  req_keep_o;
  logic        req_last_o;
  logic [7:0]  drop_cnt_o;
  logic        busy_o;

  int passed = 0;
  int total  = 0;

  mold_retrans_req dut (
    .clk              (clk),
    .nreset           (nreset),
    .miss_v_i         (miss_v_i),
    .miss_sid_i       (miss_sid_i),
    .miss_seq_start_i (miss_seq_start_i),
    .miss_cnt_i       (miss_cnt_i),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_data_o       (req_data_o),
    .req_keep_o       (req_keep_o),
    .req_last_o       (req_last_o),
    .drop_cnt_o       (drop_cnt_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference beat built from an explicit 20-byte array: {data, keep, last}.
  function automatic logic [72:0] model(input logic [79:0] sid, input logic [63:0] seq,
                                        input logic [15:0] cnt, input int b);
    logic [7:0]  by [20];
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) by[i] = sid[8*(9-i) +: 8];
    for (int i = 0; i < 8; i++) by[10+i] = seq[8*(7-i) +: 8];
    by[18] = cnt[15:8];
    by[19] = cnt[7:0];
    for (int k = 0; k < 8; k++) if (b * 8 + k < 20) d[8*k +: 8] = by[b*8+k];
    return {d, (b == 2) ? 8'h0F : 8'hFF, (b == 2)};
  endfunction

  task automatic report(input logic [79:0] sid, input logic [63:0] seq, input logic [63:0] cnt);
    miss_v_i         = 1'b1;
    miss_sid_i       = sid;
    miss_seq_start_i = seq;
    miss_cnt_i       = cnt;
    step();
    miss_v_i = 1'b0;
  endtask

  task automatic recv(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                      input string tag);
    req_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      int n = 0;
      while (!req_valid_o && n < 50) begin
        step();
        n++;
      end
      chk($sformatf("%s_beat%0d", tag, b), {req_valid_o, req_data_o, req_keep_o, req_last_o},
          {1'b1, model(sid, seq, cnt, b)});
      step();
    end
  endtask

  logic [79:0] rsid [2];
  logic [63:0] rseq [2];
  logic        pv, pl, rdy;
  logic [63:0] pd;
  logic [7:0]  pk;
  int          idx, cyc;

  initial begin
    // Reset state
    #2;
    chk("rst_outs", {req_valid_o, req_data_o, req_keep_o, req_last_o, busy_o, drop_cnt_o}, '0);
    @(negedge clk);
    nreset = 1'b1;
    step();

    // Single miss: one-cycle latency and hand-computed last beat
    req_ready_i = 1'b1;
    miss_v_i = 1'b1; miss_sid_i = 80'h1; miss_seq_start_i = 64'd5; miss_cnt_i = 64'd3;
    step();
    miss_v_i = 1'b0;
    chk("latency_valid", req_valid_o, 1'b1);
    chk("b0_data", req_data_o, 64'h0);
    chk("b0_keep", req_keep_o, 8'hFF);
    step();
    chk("b1_data", req_data_o, 64'h0000_0000_0000_0100);
    step();
    chk("b2_data", req_data_o, 64'h0000_0000_0300_0500);
    chk("b2_keep_last", {req_keep_o, req_last_o}, {8'h0F, 1'b1});
    step();
    chk("idle_after_single", {req_valid_o, busy_o}, 2'b00);

    // Zero-count report ignored, not a drop
    report(80'h7, 64'd9, 64'd0);
    chk("zero_cnt_ignored", {req_valid_o, busy_o, drop_cnt_o}, '0);

    // Chunking across the 16-bit count limit
    report(80'hAB_CDEF, 64'd5, 64'h1_0001);
    recv(80'hAB_CDEF, 64'd5, 16'hFFFF, "chunk1");
    recv(80'hAB_CDEF, 64'h1_0004, 16'h0002, "chunk2");
    chk("idle_after_chunks", {req_valid_o, busy_o}, 2'b00);

    // Sequence wraps modulo 2^64
    report(80'h55, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1_0001);
    recv(80'h55, 64'hFFFF_FFFF_FFFF_FFF0, 16'hFFFF, "wrap1");
    recv(80'h55, 64'h0000_0000_0000_FFEF, 16'h0002, "wrap2");

    // Six reports while stalled: four queued, two dropped
    req_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) report(80'h100 + 80'(i), 64'd100 * 64'(i), 64'(i + 1));
    chk("drop_two", drop_cnt_o, 8'd2);
    chk("busy_stalled", {req_valid_o, busy_o}, 2'b11);
    for (int i = 0; i < 4; i++)
      recv(80'h100 + 80'(i), 64'd100 * 64'(i), 16'(i + 1), $sformatf("queued%0d", i));
    chk("idle_after_queue", busy_o, 1'b0);

    // Drop counter saturates
    req_ready_i = 1'b0;
    miss_v_i = 1'b1; miss_sid_i = 80'h9; miss_seq_start_i = 64'd1; miss_cnt_i = 64'd1;
    for (int i = 0; i < 300; i++) step();
    miss_v_i = 1'b0;
    chk("drop_saturate", drop_cnt_o, 8'hFF);
    for (int i = 0; i < 4; i++) recv(80'h9, 64'd1, 16'd1, $sformatf("sat%0d", i));

    // Random ready: stable under stall, no beat lost or duplicated
    rsid[0] = 80'hDEAD_BEEF; rseq[0] = 64'h0102_0304_0506_0708;
    rsid[1] = 80'hFACE;      rseq[1] = 64'h1111;
    req_ready_i = 1'b0;
    report(rsid[0], rseq[0], 64'd1);
    report(rsid[1], rseq[1], 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 400) begin
      req_ready_i = 1'($urandom_range(0, 1));
      pv = req_valid_o; pd = req_data_o; pk = req_keep_o; pl = req_last_o; rdy = req_ready_i;
      step();
      cyc++;
      if (pv && rdy) begin
        chk($sformatf("rand_beat%0d", idx), {pd, pk, pl},
            model(rsid[idx/3], rseq[idx/3], 16'd1, idx % 3));
        idx++;
      end else if (pv) begin
        chk("stall_stable", {req_valid_o, req_data_o, req_keep_o, req_last_o},
            {1'b1, pd, pk, pl});
      end
    end
    chk("rand_beat_count", 32'(idx), 32'd6);
    step();
    chk("rand_idle", {req_valid_o, busy_o}, 2'b00);

    // Reset during beat 1 discards the packet
    req_ready_i = 1'b1;
    report(80'h77, 64'd42, 64'd2);
    step();
    chk("in_beat1", {req_valid_o, req_keep_o, req_last_o}, {1'b1, 8'hFF, 1'b0});
    nreset = 1'b0;
    #1;
    chk("rst_mid_pkt", {req_valid_o, req_data_o, req_keep_o, req_last_o, busy_o, drop_cnt_o}, '0);
    @(negedge clk);
    nreset = 1'b1;
    step();
    chk("no_resume", {req_valid_o, busy_o}, 2'b00);
    report(80'h88, 64'd7, 64'd1);
    recv(80'h88, 64'd7, 16'd1, "after_rst");

    // Push into full FIFO on the final B2 handshake
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) report(80'h200 + 80'(i), 64'(i), 64'd1);
    req_ready_i = 1'b1;
    step();
    step();
    chk("full_b2_last", {req_valid_o, req_last_o}, 2'b11);
    miss_v_i = 1'b1; miss_sid_i = 80'h2FF; miss_seq_start_i = 64'd99; miss_cnt_i = 64'd1;
    step();
    miss_v_i = 1'b0;
    chk("full_pop_no_drop", drop_cnt_o, 8'd0);
    for (int i = 1; i < 4; i++) recv(80'h200 + 80'(i), 64'(i), 16'd1, $sformatf("full%0d", i));
    recv(80'h2FF, 64'd99, 16'd1, "coincident_push");
    chk("final_idle", {req_valid_o, busy_o}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
